// File: rtl/dds_gen.sv
// rtl/dds_gen.sv - BCD-programmed direct digital synthesis phase generator
//
// Converts a 4-digit BCD frequency (Hz) into a phase increment with a
// serial BCD-to-binary converter followed by a serial shift-add multiplier,
// then drives a free-running phase accumulator whose top 8 bits address a
// waveform ROM.
//
// Ports:
//   signal   - 10 kHz system clock, all logic on its rising edge
//   rst_n    - synchronous active-low reset
//   fre_bcd  - target frequency, 4 BCD digits ([15:12] thousands, [3:0] units)
//   load     - apply fre_bcd; only looked at while idle
//   address  - ROM address, top 8 bits of the phase accumulator
//   busy     - a conversion is in flight
//   done     - one-cycle pulse as the new increment takes effect
//   err      - sticky: bad BCD digit or frequency above 4999 Hz

module dds_gen #(
  parameter int              ACC_W  = 32,
  parameter longint unsigned PINC_K = 64'd109951163
) (
  input  logic        signal,
  input  logic        rst_n,
  input  logic [15:0] fre_bcd,
  input  logic        load,
  output logic [7:0]  address,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int PROD_W = ACC_W + 21;
  localparam logic [PROD_W-1:0] K_EXT = PROD_W'(PINC_K);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    MULT  = 2'd2,
    APPLY = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    inc;
  logic [13:0]         bin;
  logic [13:0]         bin_calc;
  logic [PROD_W-1:0]   product;
  logic [15:0]         bcd_q;
  logic [3:0]          cnt;
  logic [3:0]          digit;
  logic                bcd_bad;
  logic                too_high;
  logic                prod_unused;

  // Only the truncated window [ACC_W+7:8] of the product becomes the increment.
  assign prod_unused = ^{product[PROD_W-1:ACC_W+8], product[7:0]};

  assign bcd_bad = (fre_bcd[15:12] > 4'd9) || (fre_bcd[11:8] > 4'd9) ||
                   (fre_bcd[7:4]   > 4'd9) || (fre_bcd[3:0]  > 4'd9);

  // Most significant digit first; cnt counts conversion steps 0..3.
  always_comb begin
    digit = 4'd0;
    case (cnt[1:0])
      2'd0:    digit = bcd_q[15:12];
      2'd1:    digit = bcd_q[11:8];
      2'd2:    digit = bcd_q[7:4];
      default: digit = bcd_q[3:0];
    endcase
  end

  // At most 999*10+9 after the fourth digit, so 14 bits never overflow.
  assign bin_calc = 14'(bin * 14'd10) + {10'd0, digit};
  assign too_high = (bin_calc > 14'd4999);

  always_ff @(posedge signal) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (load && !bcd_bad) begin
          state_nxt = CONV;
        end
      end
      CONV: begin
        if (cnt == 4'd3) begin
          state_nxt = too_high ? IDLE : MULT;
        end
      end
      MULT: begin
        if (cnt == 4'd12) begin
          state_nxt = APPLY;
        end
      end
      APPLY: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge signal) begin
    if (!rst_n) begin
      acc     <= '0;
      inc     <= '0;
      bin     <= '0;
      product <= '0;
      bcd_q   <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      // Never cleared on load: phase stays continuous across retuning.
      acc  <= acc + inc;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            if (bcd_bad) begin
              err <= 1'b1;
            end else begin
              bcd_q   <= fre_bcd;
              err     <= 1'b0;
              bin     <= '0;
              product <= '0;
              cnt     <= '0;
            end
          end
        end
        CONV: begin
          bin <= bin_calc;
          if (cnt == 4'd3) begin
            cnt     <= '0;
            product <= '0;
            if (too_high) begin
              err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        MULT: begin
          // One multiplier bit per cycle, LSB first.
          if (bin[cnt]) begin
            product <= product + (K_EXT << cnt);
          end
          cnt <= (cnt == 4'd12) ? 4'd0 : cnt + 4'd1;
        end
        APPLY: begin
          // Truncated, not rounded.
          inc  <= product[ACC_W+7:8];
          done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign address = acc[ACC_W-1 -: 8];
  assign busy    = (state != IDLE);

endmodule
